// File: rtl/ov7670_cfg_sequencer_if.sv
// Write-request bus between the OV7670 config sequencer (master) and the SCCB write engine (slave).
interface ov7670_cfg_sequencer_if;
    logic       req;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic       err;

    modport master (output req, addr, wdata, input ack, err);
    modport slave  (input req, addr, wdata, output ack, err);
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 register LUT and issues one SCCB write per entry, with power-up, gap and soft-reset delays.
// Optional macro CFG_RETRY_EN adds per-entry retries on engine error (parameter RETRY_MAX exists only then).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | parked, unused in normal flow
// PWR_WAIT | power-up / restart delay before the first write
// FETCH    | register LUT word at lut_index into addr/wdata
// ISSUE    | raise i2c_req
// WAIT_ACK | hold request until engine reports ack or err
// GAP      | inter-write delay (or soft-reset delay, or retry delay)
// DONE     | all entries written, cfg_done high
// FAIL     | aborted, cfg_err high, lut_index holds failing entry
module ov7670_cfg_sequencer #(
    parameter int          LUT_SIZE  = 164,
    parameter logic [19:0] PWRUP_DLY = 20'd1_000_000,
    parameter logic [15:0] GAP_DLY   = 16'd500,
    parameter logic [19:0] SRST_DLY  = 20'd100_000
`ifdef CFG_RETRY_EN
    ,
    parameter int          RETRY_MAX = 2
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [7:0]                    lut_index,
    input  logic [15:0]                   lut_data,
    ov7670_cfg_sequencer_if.master        i2c,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic                          cfg_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PWR_WAIT = 3'd1;
    localparam logic [2:0] FETCH    = 3'd2;
    localparam logic [2:0] ISSUE    = 3'd3;
    localparam logic [2:0] WAIT_ACK = 3'd4;
    localparam logic [2:0] GAP      = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
    localparam logic [2:0] FAIL     = 3'd7;

    localparam logic [7:0] LAST_IDX = (LUT_SIZE > 0) ? 8'(LUT_SIZE - 1) : 8'd0;

    logic [2:0]  state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [7:0]  idx_nxt, addr_nxt, wdata_nxt;
    logic        req_nxt, done_nxt, err_nxt, busy_nxt;
    logic        cnt_last, srst_write;

`ifdef CFG_RETRY_EN
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);
    logic [7:0] retry_cnt, retry_nxt;
    logic       reissue, reissue_nxt;
`endif

    // A load of N expires on the Nth cycle; a load of 0 behaves like 1.
    assign cnt_last   = (cnt <= 20'd1);
    assign srst_write = (i2c.addr == 8'h12) && i2c.wdata[7];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = lut_index;
        req_nxt   = i2c.req;
        addr_nxt  = i2c.addr;
        wdata_nxt = i2c.wdata;
        done_nxt  = cfg_done;
        err_nxt   = cfg_err;
`ifdef CFG_RETRY_EN
        retry_nxt   = retry_cnt;
        reissue_nxt = reissue;
`endif
        if (start) begin
            state_nxt = PWR_WAIT;
            cnt_nxt   = PWRUP_DLY;
            idx_nxt   = 8'd0;
            req_nxt   = 1'b0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
`ifdef CFG_RETRY_EN
            retry_nxt   = 8'd0;
            reissue_nxt = 1'b0;
`endif
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (!cnt_last) begin
                        cnt_nxt = cnt - 20'd1;
                    end else begin
                        idx_nxt = 8'd0;
                        if (LUT_SIZE == 0) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end
                end
                FETCH: begin
                    addr_nxt  = lut_data[15:8];
                    wdata_nxt = lut_data[7:0];
                    state_nxt = ISSUE;
                end
                ISSUE: begin
                    req_nxt   = 1'b1;
                    state_nxt = WAIT_ACK;
                end
                WAIT_ACK: begin
                    // err has priority over a coincident ack
                    if (i2c.err) begin
                        req_nxt = 1'b0;
`ifdef CFG_RETRY_EN
                        if (retry_cnt < RETRY_LIM) begin
                            retry_nxt   = retry_cnt + 8'd1;
                            cnt_nxt     = {4'd0, GAP_DLY};
                            reissue_nxt = 1'b1;
                            state_nxt   = GAP;
                        end else begin
                            state_nxt = FAIL;
                            err_nxt   = 1'b1;
                        end
`else
                        state_nxt = FAIL;
                        err_nxt   = 1'b1;
`endif
                    end else if (i2c.ack) begin
                        req_nxt   = 1'b0;
                        cnt_nxt   = srst_write ? SRST_DLY : {4'd0, GAP_DLY};
                        state_nxt = GAP;
`ifdef CFG_RETRY_EN
                        retry_nxt = 8'd0;
`endif
                    end
                end
                GAP: begin
                    if (!cnt_last) begin
                        cnt_nxt = cnt - 20'd1;
`ifdef CFG_RETRY_EN
                    end else if (reissue) begin
                        reissue_nxt = 1'b0;
                        state_nxt   = ISSUE;
`endif
                    end else if (lut_index == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt   = lut_index + 8'd1;
                        state_nxt = FETCH;
`ifdef CFG_RETRY_EN
                        retry_nxt = 8'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
        busy_nxt = state_nxt inside {PWR_WAIT, FETCH, ISSUE, WAIT_ACK, GAP};
    end

    // Busy is registered from the next state so it reads 0 while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= PWRUP_DLY;
            lut_index <= 8'd0;
            i2c.req   <= 1'b0;
            i2c.addr  <= 8'd0;
            i2c.wdata <= 8'd0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lut_index <= idx_nxt;
            i2c.req   <= req_nxt;
            i2c.addr  <= addr_nxt;
            i2c.wdata <= wdata_nxt;
            cfg_busy  <= busy_nxt;
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

`ifdef CFG_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= 8'd0;
            reissue   <= 1'b0;
        end else begin
            retry_cnt <= retry_nxt;
            reissue   <= reissue_nxt;
        end
    end
`endif

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
- Sequences the OV7670 register-configuration lookup table out to the SCCB/I2C write engine.
- After power-up or a `start` pulse, it walks the LUT index from 0 to `LUT_SIZE-1`, fetches each {reg, value} word and issues one write per entry.
- It inserts the required delays between writes and reports `cfg_done` or `cfg_err` to the capture pipeline, which holds off frame capture until `cfg_done` is asserted.

Parameters:
- `LUT_SIZE`, 164: number of valid LUT entries; indices 0..`LUT_SIZE-1` are written.
- `PWRUP_DLY`, 20'd1_000_000: clk cycles to wait after reset or start before the first write.
- `GAP_DLY`, 16'd500: idle clk cycles between consecutive writes.
- `SRST_DLY`, 20'd100_000: extra wait after any write to reg 0x12 with value bit7=1 (sensor soft reset).
- `RETRY_MAX`, 2: retries per entry on engine error; used only with `CFG_RETRY_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: one-cycle pulse; restarts the full sequence from index 0 from any state.
- `lut_index` out 8: LUT address.
- `lut_data` in 16: LUT word; [15:8] is reg, [7:0] is value. Combinational from `lut_index`.
- `i2c_req` out 1: write request to the SCCB engine.
- `i2c_addr` out 8: register address; stable while `i2c_req`=1.
- `i2c_wdata` out 8: register value; stable while `i2c_req`=1.
- `i2c_ack` in 1: one-cycle pulse, write completed OK.
- `i2c_err` in 1: one-cycle pulse, write failed (NACK/timeout).
- `cfg_busy` out 1: high while sequencing.
- `cfg_done` out 1: level; high once all entries are written; cleared by `start`/`rst`.
- `cfg_err` out 1: level; high on abort; cleared by `start`/`rst`.

Behaviour:
- **Reset values:** `lut_index`=0, `i2c_req`=0, `i2c_addr`=0, `i2c_wdata`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0. State goes to PWR_WAIT, so sequencing starts automatically after reset.
- **States:** IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_ACK, GAP, DONE, FAIL. `cfg_busy`=1 in PWR_WAIT, FETCH, ISSUE, WAIT_ACK and GAP.
- **PWR_WAIT:** the delay counter counts `PWRUP_DLY` cycles, then the FSM goes to FETCH with `lut_index`=0.
- **FETCH (1 cycle):** `lut_index` is already driven; `lut_data` is registered into `i2c_addr`/`i2c_wdata`. The FSM then goes to ISSUE.
- **ISSUE:** `i2c_req` is set to 1 and the FSM goes to WAIT_ACK. `i2c_req` stays high until the cycle after `i2c_ack` or `i2c_err` is seen.
- **WAIT_ACK, on `i2c_ack`:** `i2c_req` is dropped.
  - If the last write was reg 0x12 with value bit7=1, the delay load is `SRST_DLY`; otherwise it is `GAP_DLY`. The FSM goes to GAP.
  - If `i2c_ack` and `i2c_err` arrive in the same cycle, `i2c_err` wins.
- **WAIT_ACK, on `i2c_err`:** `i2c_req` is dropped. See Optional Feature; the default path is FAIL.
- **GAP:** the counter counts down to 0.
  - If `lut_index`=`LUT_SIZE-1`, the FSM goes to DONE.
  - Otherwise `lut_index` is incremented and the FSM goes to FETCH.
- **DONE:** `cfg_done`=1, `cfg_busy`=0. Holds until `start`.
- **FAIL:** `cfg_err`=1, `cfg_busy`=0. `lut_index` freezes at the failing entry for debug. Holds until `start`.
- **Index range:** `lut_index` never exceeds `LUT_SIZE-1`, so the LUT default entry is never written. `LUT_SIZE`=0 goes straight from PWR_WAIT to DONE.
- **`start` in any state:** clears `cfg_done`/`cfg_err`/`i2c_req`, sets `lut_index`=0, loads `PWRUP_DLY` and enters PWR_WAIT. An in-flight ack/err arriving after `start` is ignored.
- **`start` together with `i2c_ack`:** `start` wins.
- **Delay counter:** 20 bits, shared by PWR_WAIT and GAP. A delay of N holds the state for exactly N cycles (N=0 means 1 cycle).
- **Per-entry latency (no delays):** FETCH 1 + ISSUE 1 + engine time + GAP.

Optional Feature:
- Macro: `CFG_RETRY_EN`.
- **Defined:** on `i2c_err`, while the retry count < `RETRY_MAX`, the counter is incremented, `GAP_DLY` is waited and the same entry is re-issued via ISSUE with unchanged addr/data. The retry count resets on every `i2c_ack` or index advance. When the limit is exceeded, the FSM goes to FAIL.
- **Undefined:** the first `i2c_err` goes directly to FAIL. No retry counter is synthesized.

Test Plan:
- **Full sequence:** `LUT_SIZE`=4, `PWRUP_DLY`=10, `GAP_DLY`=3, engine acks 5 cycles after req. Release `rst` → first `i2c_req` at cycle 12. Four writes, with addr/wdata matching LUT entries 0..3. `cfg_done`=1 after the 4th gap, and `lut_index` stays 3.
- **Soft-reset delay:** LUT entry 1 = 16'h1280, `SRST_DLY`=50 → the gap after that write is 50 cycles; other gaps are 3.
- **Error abort (macro undefined):** `i2c_err` pulse on entry 2 → `cfg_err`=1, `cfg_busy`=0, `lut_index`=2, no further `i2c_req`.
- **Retry (`CFG_RETRY_EN`, `RETRY_MAX`=2):** err, err, ack on entry 1 → three requests with identical addr/data, then the sequence continues. Err ×3 → FAIL with `lut_index`=1.
- **Mid-operation restart:** assert `start` during WAIT_ACK on entry 2, with a late `i2c_ack` 2 cycles later → ack ignored, `i2c_req`=0 for `PWRUP_DLY`, then a write of entry 0.
- **Async reset mid-GAP:** assert `rst` mid-GAP → all outputs 0 immediately, without waiting for a clock edge. After release, the sequence restarts from index 0.
